// File: rtl/alu_logic_seq_if.sv
// Bundle between the control sequencer, the operand/result stage and the
// 8-bit logic unit: bus loads, command, operands out, result back.
interface alu_logic_seq_if;
    logic [7:0] busData;
    logic       ldAcc;
    logic       ldTmp;
    logic       exec;
    logic [2:0] opSel;
    logic       flagOnly;
    logic [7:0] logA;
    logic [7:0] logB;
    logic [2:0] logSel;
    logic [7:0] logRes;
    logic [7:0] accOut;
    logic [7:0] flags;
    logic       busy;
    logic       done;

    modport slave (
        input  busData, ldAcc, ldTmp, exec, opSel, flagOnly, logRes,
        output logA, logB, logSel, accOut, flags, busy, done
    );

    modport master (
        output busData, ldAcc, ldTmp, exec, opSel, flagOnly, logRes,
        input  logA, logB, logSel, accOut, flags, busy, done
    );
endinterface

// File: rtl/alu_logic_seq.sv
// Operand/result sequencing stage around the 8-bit logic unit: holds ACC and TMP,
// runs IDLE -> EXEC -> DONE, and writes the result into ACC and the 8085 flags.
module alu_logic_seq (
    input  logic           clk,
    input  logic           rst,
    alu_logic_seq_if.slave seqIf
);
    typedef enum logic [2:0] {
        IDLE = 3'b001,
        EXEC = 3'b010,
        DONE = 3'b100
    } StateT;

    StateT      stateQ, stateD;
    logic [7:0] accQ, accD;
    logic [7:0] tmpQ, tmpD;
    logic [2:0] opQ, opD;
    logic       modeQ, modeD;
    logic [7:0] flagsQ, flagsD;
    logic [7:0] resFlags;

    // 8085 layout {S,Z,0,AC,0,P,1,CY}; AC mirrors the 8085 convention of setting it on AND
    always_comb begin
        resFlags = {seqIf.logRes[7],
                    (seqIf.logRes == 8'h00),
                    1'b0,
                    (opQ[1:0] == 2'b00),
                    1'b0,
                    ~^seqIf.logRes,
                    1'b1,
                    1'b0};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stateQ <= IDLE;
            accQ   <= 8'h00;
            tmpQ   <= 8'h00;
            opQ    <= 3'b000;
            modeQ  <= 1'b0;
            flagsQ <= 8'h02;
        end else begin
            stateQ <= stateD;
            accQ   <= accD;
            tmpQ   <= tmpD;
            opQ    <= opD;
            modeQ  <= modeD;
            flagsQ <= flagsD;
        end
    end

    always_comb begin
        stateD = stateQ;
        accD   = accQ;
        tmpD   = tmpQ;
        opD    = opQ;
        modeD  = modeQ;
        flagsD = flagsQ;
        unique case (stateQ)
            IDLE: begin
                // Loads land on the same edge that accepts exec, so EXEC sees the new operands
                if (seqIf.ldAcc) accD = seqIf.busData;
                if (seqIf.ldTmp) tmpD = seqIf.busData;
                if (seqIf.exec) begin
                    opD    = seqIf.opSel;
                    modeD  = seqIf.flagOnly;
                    stateD = EXEC;
                end
            end
            EXEC: begin
                if (!modeQ) accD = seqIf.logRes;
                flagsD = resFlags;
                stateD = DONE;
            end
            DONE: begin
                stateD = IDLE;
            end
            default: begin
                stateD = IDLE;
            end
        endcase
    end

    assign seqIf.logA   = accQ;
    assign seqIf.logB   = tmpQ;
    assign seqIf.logSel = opQ;
    assign seqIf.accOut = accQ;
    assign seqIf.flags  = flagsQ;
    assign seqIf.busy   = (stateQ == EXEC);
    assign seqIf.done   = (stateQ == DONE);
endmodule

// File: tb/tb_alu_logic_seq.sv
// Directed plus short random bench for alu_logic_seq; models the logic unit
// and checks ACC/flags through a scoreboard queue filled at exec time.
module tb_alu_logic_seq;
    typedef struct packed {
        logic [7:0] acc;
        logic [7:0] flags;
    } ExpT;

    logic clk;
    logic rst;
    int   checks;
    int   failures;
    ExpT  sbQ[$];

    alu_logic_seq_if seqIf ();

    alu_logic_seq dut (
        .clk   (clk),
        .rst   (rst),
        .seqIf (seqIf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [7:0] unitModel(input logic [7:0] a, input logic [7:0] b,
                                             input logic [2:0] sel);
        case (sel[1:0])
            2'b00:   return a & b;
            2'b01:   return a ^ b;
            2'b10:   return a | b;
            default: return a;
        endcase
    endfunction

    function automatic logic [7:0] flagModel(input logic [7:0] r, input logic [2:0] sel);
        int ones;
        ones = $countones(r);
        return {r[7], (r == 8'h00), 1'b0, (sel[1:0] == 2'b00), 1'b0,
                ((ones % 2) == 0), 1'b1, 1'b0};
    endfunction

    // The logic unit itself is combinational and lives outside the DUT
    always_comb seqIf.logRes = unitModel(seqIf.logA, seqIf.logB, seqIf.logSel);

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic loadRegs(input logic [7:0] a, input logic [7:0] t);
        seqIf.ldAcc   = 1'b1;
        seqIf.busData = a;
        tick();
        seqIf.ldAcc   = 1'b0;
        seqIf.ldTmp   = 1'b1;
        seqIf.busData = t;
        tick();
        seqIf.ldTmp   = 1'b0;
    endtask

    // Issues exec (optionally with a same-cycle ACC load), pushes the expectation and checks EXEC
    task automatic applyStimulus(input logic [2:0] op, input logic fo, input logic ldA,
                                 input logic [7:0] ldVal, input logic [7:0] expA,
                                 input logic [7:0] expB, input logic [7:0] expAcc,
                                 input logic [7:0] expFlags);
        ExpT e;
        seqIf.exec     = 1'b1;
        seqIf.opSel    = op;
        seqIf.flagOnly = fo;
        seqIf.ldAcc    = ldA;
        seqIf.busData  = ldVal;
        e.acc   = expAcc;
        e.flags = expFlags;
        sbQ.push_back(e);
        tick();
        seqIf.exec  = 1'b0;
        seqIf.ldAcc = 1'b0;
        check("busyInExec", {7'd0, seqIf.busy}, 8'h01);
        check("logA", seqIf.logA, expA);
        check("logB", seqIf.logB, expB);
        check("logSel", {5'd0, seqIf.logSel}, {5'd0, op});
    endtask

    task automatic checkOutput();
        ExpT e;
        logic seen;
        seen = 1'b0;
        for (int i = 0; i < 8 && !seen; i++) begin
            @(negedge clk);
            if (seqIf.done) seen = 1'b1;
        end
        check("doneSeen", {7'd0, seen}, 8'h01);
        check("sbNotEmpty", {7'd0, (sbQ.size() > 0)}, 8'h01);
        if (sbQ.size() > 0) begin
            e = sbQ.pop_front();
            check("accOut", seqIf.accOut, e.acc);
            check("flags", seqIf.flags, e.flags);
        end
        @(negedge clk);
        check("donePulseEnds", {7'd0, seqIf.done}, 8'h00);
        check("busyIdle", {7'd0, seqIf.busy}, 8'h00);
    endtask

    initial begin
        logic [7:0] a, t, r, expAcc;
        logic [2:0] op;
        logic       fo;
        checks   = 0;
        failures = 0;
        rst            = 1'b1;
        seqIf.busData  = 8'h00;
        seqIf.ldAcc    = 1'b0;
        seqIf.ldTmp    = 1'b0;
        seqIf.exec     = 1'b0;
        seqIf.opSel    = 3'b000;
        seqIf.flagOnly = 1'b0;
        #12;
        check("rstAcc", seqIf.accOut, 8'h00);
        check("rstFlags", seqIf.flags, 8'h02);
        check("rstBusy", {7'd0, seqIf.busy}, 8'h00);
        check("rstDone", {7'd0, seqIf.done}, 8'h00);
        check("rstLogA", seqIf.logA, 8'h00);
        check("rstLogB", seqIf.logB, 8'h00);
        check("rstLogSel", {5'd0, seqIf.logSel}, 8'h00);
        @(negedge clk);
        rst = 1'b0;
        tick();

        $display("[TB] AND / XOR-to-zero / OR sign");
        loadRegs(8'hF0, 8'h3C);
        applyStimulus(3'b000, 1'b0, 1'b0, 8'h00, 8'hF0, 8'h3C, 8'h30, 8'h16);
        checkOutput();
        loadRegs(8'h5A, 8'h5A);
        applyStimulus(3'b001, 1'b0, 1'b0, 8'h00, 8'h5A, 8'h5A, 8'h00, 8'h46);
        checkOutput();
        loadRegs(8'h80, 8'h01);
        applyStimulus(3'b010, 1'b0, 1'b0, 8'h00, 8'h80, 8'h01, 8'h81, 8'h86);
        checkOutput();

        $display("[TB] same-cycle load, flagOnly, opSel[2] pass-through");
        applyStimulus(3'b010, 1'b0, 1'b1, 8'h0F, 8'h0F, 8'h01, 8'h0F, 8'h06);
        checkOutput();
        loadRegs(8'hAA, 8'h55);
        applyStimulus(3'b001, 1'b1, 1'b0, 8'h00, 8'hAA, 8'h55, 8'hAA, 8'h86);
        checkOutput();
        loadRegs(8'h33, 8'h07);
        applyStimulus(3'b111, 1'b0, 1'b0, 8'h00, 8'h33, 8'h07, 8'h33, 8'h06);
        checkOutput();

        $display("[TB] busy rejection");
        loadRegs(8'h0C, 8'h0A);
        applyStimulus(3'b000, 1'b0, 1'b0, 8'h00, 8'h0C, 8'h0A, 8'h08, 8'h12);
        seqIf.exec    = 1'b1;
        seqIf.ldAcc   = 1'b1;
        seqIf.ldTmp   = 1'b1;
        seqIf.busData = 8'hFF;
        seqIf.opSel   = 3'b010;
        tick();
        check("rejDone", {7'd0, seqIf.done}, 8'h01);
        check("rejAccInDone", seqIf.accOut, 8'h08);
        check("rejFlagsInDone", seqIf.flags, 8'h12);
        tick();
        seqIf.exec  = 1'b0;
        seqIf.ldAcc = 1'b0;
        seqIf.ldTmp = 1'b0;
        void'(sbQ.pop_front());
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("rejNoSecondDone", {7'd0, seqIf.done}, 8'h00);
            check("rejNoBusy", {7'd0, seqIf.busy}, 8'h00);
        end
        check("rejAccKept", seqIf.accOut, 8'h08);
        check("rejTmpKept", seqIf.logB, 8'h0A);
        tick();

        $display("[TB] reset during EXEC");
        loadRegs(8'h55, 8'h0F);
        seqIf.exec  = 1'b1;
        seqIf.opSel = 3'b000;
        tick();
        seqIf.exec = 1'b0;
        check("preRstBusy", {7'd0, seqIf.busy}, 8'h01);
        #3;
        rst = 1'b1;
        #1;
        check("midRstAcc", seqIf.accOut, 8'h00);
        check("midRstFlags", seqIf.flags, 8'h02);
        check("midRstBusy", {7'd0, seqIf.busy}, 8'h00);
        check("midRstDone", {7'd0, seqIf.done}, 8'h00);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("postRstDone", {7'd0, seqIf.done}, 8'h00);
            check("postRstAcc", seqIf.accOut, 8'h00);
            check("postRstFlags", seqIf.flags, 8'h02);
        end
        tick();
        loadRegs(8'h12, 8'h34);
        applyStimulus(3'b010, 1'b0, 1'b0, 8'h00, 8'h12, 8'h34, 8'h36, 8'h06);
        checkOutput();

        $display("[TB] random operations");
        for (int n = 0; n < 8; n++) begin
            a  = 8'($urandom);
            t  = 8'($urandom);
            op = 3'($urandom_range(0, 7));
            fo = 1'($urandom_range(0, 1));
            r  = unitModel(a, t, op);
            expAcc = fo ? a : r;
            tick();
            loadRegs(a, t);
            applyStimulus(op, fo, 1'b0, 8'h00, a, t, expAcc, flagModel(r, op));
            checkOutput();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
